// File: rtl/mult_unit_if.sv
// EX-stage multiplier bus: ALU control/operand inputs and HI/LO/stall/done outputs.
interface mult_unit_if #(
    parameter int WIDTH = 32
);
    logic [5:0]       alu_ctrl;
    logic             valid;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output alu_ctrl, valid, op_a, op_b,
        input  stall, done, hi_out, lo_out
    );

    modport slave (
        input  alu_ctrl, valid, op_a, op_b,
        output stall, done, hi_out, lo_out
    );
endinterface

// File: rtl/mult_unit.sv
// Iterative unsigned shift-add multiplier with HI/LO result registers.
// Optional MULT_EARLY_EXIT_EN: finish RUN as soon as the remaining multiplier bits are zero.
//
// state | meaning
// IDLE  | waiting for a valid MULTU in EX
// RUN   | one multiplier bit consumed per cycle, pipeline stalled
// DONE  | HI/LO just written, done pulse, pipeline released
module mult_unit #(
    parameter int          WIDTH      = 32,
    parameter logic [5:0]  MULTU_CODE = 6'h13
) (
    input  logic       clk,
    input  logic       rst_n,
    mult_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               accept;
    logic               last_step;
    logic               finish;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   mplier_nxt;
    logic [2*WIDTH-1:0] acc_shift;
    logic [2*WIDTH-1:0] result;

    assign accept = (state_q == S_IDLE) && bus.valid && (bus.alu_ctrl == MULTU_CODE);
    assign finish = (state_q == S_RUN) && last_step;

    // Add into the upper half with a one-bit carry extension, then shift the whole thing right.
    always_comb begin
        sum        = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        acc_shift  = {sum, acc_q[WIDTH-1:1]};
        mplier_nxt = mplier_q >> 1;
`ifdef MULT_EARLY_EXIT_EN
        last_step  = (cnt_q == CNT_LAST) || (mplier_nxt == '0);
        result     = acc_shift >> (CNT_LAST - cnt_q);
`else
        last_step  = (cnt_q == CNT_LAST);
        result     = acc_shift;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN:   if (finish) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = finish;
        if (accept) begin
            mcand_d  = bus.op_a;
            mplier_d = bus.op_b;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (state_q == S_RUN) begin
            acc_d    = acc_shift;
            mplier_d = mplier_nxt;
            cnt_d    = cnt_q + CW'(1);
            if (finish) begin
                hi_d = result[2*WIDTH-1:WIDTH];
                lo_d = result[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    // Stall covers the accept cycle so the MULTU stays in EX; DONE releases the pipeline.
    always_comb begin
        bus.stall  = accept || (state_q == S_RUN);
        bus.done   = done_q;
        bus.hi_out = hi_q;
        bus.lo_out = lo_q;
    end
endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: directed cases plus randomized multiplies against a product/latency model.
module tb_mult_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    mult_unit_if #(.WIDTH(W)) bus ();

    mult_unit #(.WIDTH(W), .MULTU_CODE(6'h13)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // RUN cycles: always W, or with early exit the bit length of the multiplier (at least 1).
    function automatic int exp_run(input logic [W-1:0] b);
        int n;
        n = W;
`ifdef MULT_EARLY_EXIT_EN
        n = 1;
        for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
`endif
        return n;
    endfunction

    // Called at a negedge with the unit idle (or in DONE when after_done is set).
    task automatic mult_op(input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit after_done, input bit hold_next);
        logic [63:0] prod;
        int stalls;
        bit seen;
        prod = 64'(a) * 64'(b);
        bus.alu_ctrl = 6'h13;
        bus.valid    = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        if (after_done) begin
            #1;
            check("done_ignores_multu", 64'(bus.stall), 64'd0);
            @(negedge clk);
        end
        #1;
        check("accept_stall", 64'(bus.stall), 64'd1);
        check("hi_held_at_accept", 64'(bus.hi_out), 64'(exp_hi));
        check("lo_held_at_accept", 64'(bus.lo_out), 64'(exp_lo));
        stalls = 1;
        seen   = 1'b0;
        for (int i = 0; i < 3 * W && !seen; i++) begin
            @(negedge clk);
            if (i == 0) begin
                bus.op_a = ~a;
                bus.op_b = ~b;
            end
            if (bus.done) seen = 1'b1;
            else if (bus.stall) stalls++;
        end
        check("done_seen", 64'(seen), 64'd1);
        check("stall_len", 64'(stalls), 64'(exp_run(b) + 1));
        check("stall_in_done", 64'(bus.stall), 64'd0);
        check("hi_out", 64'(bus.hi_out), 64'(prod[63:32]));
        check("lo_out", 64'(bus.lo_out), 64'(prod[31:0]));
        exp_hi = prod[63:32];
        exp_lo = prod[31:0];
        if (!hold_next) begin
            bus.valid    = 1'b0;
            bus.alu_ctrl = 6'h00;
            @(negedge clk);
            check("done_one_cycle", 64'(bus.done), 64'd0);
            check("no_reaccept", 64'(bus.stall), 64'd0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hold, nhold;
        logic [W-1:0] ra, rb;
        logic [5:0] code;

        bus.alu_ctrl = 6'h00;
        bus.valid    = 1'b0;
        bus.op_a     = '0;
        bus.op_b     = '0;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_hi", 64'(bus.hi_out), 64'd0);
        check("rst_lo", 64'(bus.lo_out), 64'd0);
        check("rst_stall", 64'(bus.stall), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);

        bus.alu_ctrl = 6'h02;
        bus.valid    = 1'b1;
        bus.op_a     = 5;
        bus.op_b     = 6;
        repeat (4) begin
            @(negedge clk);
            check("nop_stall", 64'(bus.stall), 64'd0);
            check("nop_done", 64'(bus.done), 64'd0);
        end
        bus.valid = 1'b0;
        @(negedge clk);

        mult_op(32'd7, 32'd6, 0, 0);
        mult_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);

        bus.alu_ctrl = 6'h13;
        bus.valid    = 1'b0;
        bus.op_a     = 9;
        bus.op_b     = 9;
        repeat (3) begin
            @(negedge clk);
            check("invalid_stall", 64'(bus.stall), 64'd0);
            check("invalid_done", 64'(bus.done), 64'd0);
            check("invalid_lo", 64'(bus.lo_out), 64'(exp_lo));
        end

        // Reset during RUN discards the partial product and clears HI/LO.
        bus.alu_ctrl = 6'h13;
        bus.valid    = 1'b1;
        bus.op_a     = 32'h1234;
        bus.op_b     = 32'hFFFF_0000;
        #1;
        check("mid_rst_accept", 64'(bus.stall), 64'd1);
        repeat (10) @(negedge clk);
        check("mid_rst_running", 64'(bus.stall), 64'd1);
        #2;
        bus.valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("mid_rst_stall", 64'(bus.stall), 64'd0);
        check("mid_rst_hi", 64'(bus.hi_out), 64'd0);
        check("mid_rst_lo", 64'(bus.lo_out), 64'd0);
        exp_hi = '0;
        exp_lo = '0;
        repeat (2) begin
            @(negedge clk);
            check("mid_rst_no_done", 64'(bus.done), 64'd0);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_no_done", 64'(bus.done), 64'd0);
        end
        mult_op(32'd3, 32'd5, 0, 0);

        mult_op(32'd2, 32'd3, 0, 1);
        mult_op(32'h0001_0000, 32'h0001_0000, 1, 0);

        mult_op(32'h1234_5678, 32'd0, 0, 0);
        mult_op(32'h8000_0000, 32'd3, 0, 0);
        mult_op(32'hDEAD_BEEF, 32'h8000_0000, 0, 0);

        hold = 1'b0;
        for (int n = 0; n < 25; n++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            nhold = (n < 24) ? 1'($urandom_range(0, 1)) : 1'b0;
            mult_op(ra, rb, hold, nhold);
            hold = nhold;
            if (!hold) begin
                repeat ($urandom_range(0, 3)) begin
                    code = 6'($urandom_range(0, 63));
                    if (code == 6'h13) code = 6'h14;
                    bus.alu_ctrl = code;
                    bus.valid    = 1'($urandom_range(0, 1));
                    bus.op_a     = $urandom;
                    bus.op_b     = $urandom;
                    #1;
                    check("gap_stall", 64'(bus.stall), 64'd0);
                    @(negedge clk);
                    check("gap_done", 64'(bus.done), 64'd0);
                    check("gap_hi", 64'(bus.hi_out), 64'(exp_hi));
                end
                bus.valid = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
